// File: rtl/irq_id_arbiter_hs.sv
// Interrupt ID arbiter with a valid/ack handshake toward the core.
// Latches event pulses into a pending buffer and picks one masked line.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   irq_event_i    : per-line single-cycle event pulses
//   irq_mask_i     : per-line enable (1 = eligible)
//   clear_all_i    : synchronous clear of every pending bit
//   irq_ack_i      : core accepts the presented ID
//   irq_req_o      : an ID is being presented
//   irq_id_o       : presented ID, all-ones when none
//   pending_o      : raw pending buffer
module irq_id_arbiter_hs #(
   parameter int NUM_IRQ  = 64,
   parameter int ID_WIDTH = 8,
   parameter int RR_MODE  = 0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NUM_IRQ-1:0]  irq_event_i,
   input  logic [NUM_IRQ-1:0]  irq_mask_i,
   input  logic                clear_all_i,
   input  logic                irq_ack_i,
   output logic                irq_req_o,
   output logic [ID_WIDTH-1:0] irq_id_o,
   output logic [NUM_IRQ-1:0]  pending_o
);

   localparam int PTR_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam logic [ID_WIDTH-1:0] NO_ID = '1;
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_IRQ - 1);

   typedef enum logic {
      IDLE,
      REQ
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_IRQ-1:0]  pend_q, pend_d;
   logic [NUM_IRQ-1:0]  elig;
   logic [NUM_IRQ-1:0]  id_oh;
   logic [NUM_IRQ-1:0]  ack_clr;
   logic                req_q, req_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [ID_WIDTH-1:0] win_lo, win_hi, win_id;
   logic                win_hi_vld;
   logic                sel_masked;

   assign elig = pend_q & irq_mask_i;

   // One-hot of the presented ID; avoids indexing with a wider ID.
   always_comb begin
      id_oh = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         id_oh[i] = (id_q == ID_WIDTH'(i));
      end
   end

   assign sel_masked = ~|(id_oh & irq_mask_i);

   // win_lo: lowest eligible line overall.
   // win_hi: lowest eligible line at or above ptr (round-robin only);
   // falling back to win_lo gives the wrap to index 0.
   always_comb begin
      win_lo     = NO_ID;
      win_hi     = NO_ID;
      win_hi_vld = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_lo = ID_WIDTH'(i);
            if (RR_MODE != 0 && i >= int'(ptr_q)) begin
               win_hi     = ID_WIDTH'(i);
               win_hi_vld = 1'b1;
            end
         end
      end
      win_id = win_hi_vld ? win_hi : win_lo;
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      ack_clr = '0;
      unique case (state_q)
         IDLE: begin
            if ((|elig) && !clear_all_i) begin
               state_d = REQ;
               req_d   = 1'b1;
               id_d    = win_id;
            end else begin
               req_d = 1'b0;
               id_d  = NO_ID;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               ack_clr = id_oh;
               state_d = IDLE;
               req_d   = 1'b0;
               id_d    = NO_ID;
               if (id_q == LAST_ID) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = PTR_W'(id_q + ID_WIDTH'(1));
               end
            end else if (sel_masked || clear_all_i) begin
               state_d = IDLE;
               req_d   = 1'b0;
               id_d    = NO_ID;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            id_d    = NO_ID;
         end
      endcase
   end

   // A new event overrides an ack-clear; clear_all overrides everything.
   always_comb begin
      if (clear_all_i) begin
         pend_d = '0;
      end else begin
         pend_d = (pend_q & ~ack_clr) | irq_event_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pend_q  <= '0;
         req_q   <= 1'b0;
         id_q    <= NO_ID;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign irq_req_o = req_q;
   assign irq_id_o  = id_q;
   assign pending_o = pend_q;

endmodule

// File: tb/tb_irq_id_arbiter_hs.sv
// Self-checking bench for irq_id_arbiter_hs.
// Runs a fixed-priority and a round-robin instance side by side.
module tb_irq_id_arbiter_hs;

   logic        clk;
   logic        rst_n;
   logic [63:0] ev;
   logic [63:0] mask;
   logic        clr;
   logic        ack0, ack1;
   logic        req0, req1;
   logic [7:0]  id0, id1;
   logic [63:0] pend0, pend1;

   int checks;
   int errors;

   int          pres [2];
   logic [63:0] mp   [2];
   int          mptr [2];

   irq_id_arbiter_hs #(
      .NUM_IRQ (64),
      .ID_WIDTH(8),
      .RR_MODE (0)
   ) dut0 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .irq_event_i(ev),
      .irq_mask_i (mask),
      .clear_all_i(clr),
      .irq_ack_i  (ack0),
      .irq_req_o  (req0),
      .irq_id_o   (id0),
      .pending_o  (pend0)
   );

   irq_id_arbiter_hs #(
      .NUM_IRQ (64),
      .ID_WIDTH(8),
      .RR_MODE (1)
   ) dut1 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .irq_event_i(ev),
      .irq_mask_i (mask),
      .clear_all_i(clr),
      .irq_ack_i  (ack1),
      .irq_req_o  (req1),
      .irq_id_o   (id1),
      .pending_o  (pend1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(logic [63:0] e, int base);
      for (int k = 0; k < 64; k++) begin
         int idx;
         idx = (base + k) % 64;
         if (e[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic get_req(int m);
      return (m == 0) ? req0 : req1;
   endfunction

   function automatic logic [7:0] get_id(int m);
      return (m == 0) ? id0 : id1;
   endfunction

   function automatic logic [63:0] get_pend(int m);
      return (m == 0) ? pend0 : pend1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         pres[m] = -1;
         mp[m]   = '0;
         mptr[m] = 0;
      end
   endtask

   // One clock: model predicts from the inputs now applied, then
   // both instances are compared 1 time unit after the edge.
   task automatic step();
      logic [63:0] nxp [2];
      int          npres [2];
      int          nptr [2];
      logic        a;
      logic [63:0] el;
      logic [7:0]  eid;
      for (int m = 0; m < 2; m++) begin
         a        = (m == 0) ? ack0 : ack1;
         nxp[m]   = mp[m];
         npres[m] = pres[m];
         nptr[m]  = mptr[m];
         if (pres[m] >= 0 && a) nxp[m][pres[m]] = 1'b0;
         nxp[m] = nxp[m] | ev;
         if (clr) nxp[m] = '0;
         if (pres[m] < 0) begin
            el = mp[m] & mask;
            if (el != 0 && !clr)
               npres[m] = pick(el, (m == 1) ? mptr[m] : 0);
         end else if (a) begin
            npres[m] = -1;
            nptr[m]  = (pres[m] + 1) % 64;
         end else if (!mask[pres[m]] || clr) begin
            npres[m] = -1;
         end
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         mp[m]   = nxp[m];
         pres[m] = npres[m];
         mptr[m] = nptr[m];
         eid = (pres[m] < 0) ? 8'hFF : 8'(pres[m]);
         checks++;
         if (get_req(m) !== (pres[m] >= 0) ||
             get_id(m) !== eid ||
             get_pend(m) !== mp[m]) begin
            errors++;
            $display("FAIL model[%0d] t=%0t req=%b id=%0d pend=%h want req=%b id=%0d pend=%h",
                     m, $time, get_req(m), get_id(m), get_pend(m),
                     pres[m] >= 0, eid, mp[m]);
         end
      end
   endtask

   task automatic wait_req(input int m, input int max);
      int n;
      n = 0;
      while (!get_req(m) && n < max) begin
         step();
         n++;
      end
      checks++;
      if (!get_req(m)) begin
         errors++;
         $display("FAIL wait_req[%0d] timeout req=%b want 1", m, get_req(m));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ev    = '0;
      mask  = '1;
      clr   = 1'b0;
      ack0  = 1'b0;
      ack1  = 1'b0;
      #2;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (req0 !== 1'b0 || id0 !== 8'hFF || pend0 !== '0) begin
         errors++;
         $display("FAIL reset0 req=%b id=%h pend=%h want 0/ff/0", req0, id0, pend0);
      end
      checks++;
      if (req1 !== 1'b0 || id1 !== 8'hFF || pend1 !== '0) begin
         errors++;
         $display("FAIL reset1 req=%b id=%h pend=%h want 0/ff/0", req1, id1, pend1);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      ev = '0;
      ev[5] = 1'b1; ev[3] = 1'b1; ev[40] = 1'b1;
      step();
      ev = '0;
      step();
      checks++;
      if (req0 !== 1'b1 || id0 !== 8'd3) begin
         errors++;
         $display("FAIL fixed_c2 req=%b id=%0d want 1/3", req0, id0);
      end
      step();
      step();
      ack0 = 1'b1;
      step();
      ack0 = 1'b0;
      step();
      checks++;
      if (req0 !== 1'b1 || id0 !== 8'd5) begin
         errors++;
         $display("FAIL fixed_c6 req=%b id=%0d want 1/5", req0, id0);
      end
      ack0 = 1'b1;
      step();
      ack0 = 1'b0;
      step();
      checks++;
      if (req0 !== 1'b1 || id0 !== 8'd40) begin
         errors++;
         $display("FAIL fixed_third req=%b id=%0d want 1/40", req0, id0);
      end
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{2, 7, 9, 2, 7};
      int cur;
      do_reset();
      ev = '0;
      ev[2] = 1'b1; ev[7] = 1'b1; ev[9] = 1'b1;
      step();
      ev = '0;
      for (int k = 0; k < 5; k++) begin
         wait_req(1, 10);
         checks++;
         if (id1 !== 8'(exp_seq[k])) begin
            errors++;
            $display("FAIL rr_seq[%0d] id=%0d want %0d", k, id1, exp_seq[k]);
         end
         cur = int'(id1);
         ack1 = 1'b1;
         ev = '0;
         if (cur < 64) ev[cur] = 1'b1;
         step();
         ack1 = 1'b0;
         ev = '0;
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      ev = '0;
      ev[4] = 1'b1;
      step();
      ev = '0;
      wait_req(0, 5);
      ack0 = 1'b1;
      ev[4] = 1'b1;
      step();
      ack0 = 1'b0;
      ev = '0;
      checks++;
      if (pend0[4] !== 1'b1 || req0 !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_p4 p4=%b req=%b want 1/0", pend0[4], req0);
      end
      step();
      checks++;
      if (req0 !== 1'b1 || id0 !== 8'd4) begin
         errors++;
         $display("FAIL same_cycle_re req=%b id=%0d want 1/4", req0, id0);
      end
   endtask

   task automatic test_mask_withdraw();
      do_reset();
      ev = '0;
      ev[6] = 1'b1;
      step();
      ev = '0;
      wait_req(0, 5);
      mask[6] = 1'b0;
      step();
      checks++;
      if (req0 !== 1'b0 || pend0[6] !== 1'b1 || id0 !== 8'hFF) begin
         errors++;
         $display("FAIL mask_wd req=%b p6=%b id=%h want 0/1/ff", req0, pend0[6], id0);
      end
      repeat (3) step();
      mask[6] = 1'b1;
      wait_req(0, 4);
      checks++;
      if (id0 !== 8'd6) begin
         errors++;
         $display("FAIL mask_re id=%0d want 6", id0);
      end
   endtask

   task automatic test_clear_all();
      do_reset();
      ev = '0;
      ev[1] = 1'b1; ev[63] = 1'b1;
      step();
      ev = '0;
      wait_req(0, 5);
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (pend0 !== '0 || req0 !== 1'b0 || id0 !== 8'hFF) begin
         errors++;
         $display("FAIL clear_all pend=%h req=%b id=%h want 0/0/ff", pend0, req0, id0);
      end
      repeat (5) step();
      checks++;
      if (req0 !== 1'b0 || req1 !== 1'b0) begin
         errors++;
         $display("FAIL clear_quiet req0=%b req1=%b want 0/0", req0, req1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ev = '0;
      ev[12] = 1'b1;
      step();
      ev = '0;
      wait_req(0, 5);
      #2;
      rst_n = 1'b0;
      ev[12] = 1'b1;
      #1;
      checks++;
      if (req0 !== 1'b0 || id0 !== 8'hFF || pend0 !== '0) begin
         errors++;
         $display("FAIL reset_mid req=%b id=%h pend=%h want 0/ff/0", req0, id0, pend0);
      end
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (pend0 !== '0 || pend1 !== '0) begin
         errors++;
         $display("FAIL reset_ev pend0=%h pend1=%h want 0", pend0, pend1);
      end
      rst_n = 1'b1;
      ev = '0;
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ev = '0;
         if ($urandom_range(0, 2) == 0) ev[$urandom_range(0, 63)] = 1'b1;
         if ($urandom_range(0, 7) == 0) ev[$urandom_range(0, 63)] = 1'b1;
         mask = '1;
         if ($urandom_range(0, 3) == 0) mask = {$urandom, $urandom};
         clr  = ($urandom_range(0, 39) == 0);
         ack0 = $urandom_range(0, 1) == 1;
         ack1 = $urandom_range(0, 1) == 1;
         step();
      end
      ev   = '0;
      mask = '1;
      clr  = 1'b0;
      ack0 = 1'b0;
      ack1 = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      ev     = '0;
      mask   = '1;
      clr    = 1'b0;
      ack0   = 1'b0;
      ack1   = 1'b0;
      model_reset();
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_same_cycle();
      test_mask_withdraw();
      test_clear_all();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_id_arbiter_hs.md
IRQ_ID_ARBITER_HS -- requirements
Module: irq_id_arbiter_hs

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 64, meaning number of interrupt lines (2..256).
REQ-002 SHALL have parameter ID_WIDTH, default 8, meaning width of irq_id_o; it SHALL satisfy 2^ID_WIDTH > NUM_IRQ.
REQ-003 SHALL have parameter RR_MODE, default 0, meaning arbitration mode:
- 0: fixed priority, lowest index wins.
- 1: round-robin.
REQ-004 SHALL have port clk_i, input, 1 bit, meaning the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-006 SHALL have port irq_event_i, input, NUM_IRQ bits, meaning single-cycle event pulses per line.
REQ-007 SHALL have port irq_mask_i, input, NUM_IRQ bits, meaning per-line enable (1 = eligible).
REQ-008 SHALL have port clear_all_i, input, 1 bit, meaning synchronous clear of all pending bits.
REQ-009 SHALL have port irq_ack_i, input, 1 bit, meaning the core accepts the presented ID.
REQ-010 SHALL have port irq_req_o, output, 1 bit, meaning a masked-pending interrupt is presented.
REQ-011 SHALL have port irq_id_o, output, ID_WIDTH bits, meaning the presented ID; all-ones when none.
REQ-012 SHALL have port pending_o, output, NUM_IRQ bits, meaning the pending buffer, unmasked.

Function
REQ-013 SHALL keep a pending register P:
- bit i is set the edge after irq_event_i[i]=1.
- bit i is cleared the edge after an accepted ack of ID i.
- all bits are cleared the edge after clear_all_i=1.
REQ-014 SHALL resolve same-cycle conflicts on P as follows:
- set beats ack-clear on the same bit, so the bit stays pending.
- clear_all_i beats both set and ack-clear.
REQ-015 SHALL use an FSM with two states, IDLE and REQ.
REQ-016 In IDLE, when (P & irq_mask_i) != 0 and clear_all_i=0, it SHALL register the winner into irq_id_o, set irq_req_o=1 and go to REQ on the next edge.
REQ-017 In IDLE with no eligible line, it SHALL hold irq_req_o=0 and irq_id_o=all-ones.
REQ-018 In REQ, it SHALL hold irq_id_o and irq_req_o stable until one of the following occurs:
- ack: irq_ack_i=1.
- withdrawal: irq_mask_i[irq_id_o]=0, or clear_all_i=1.
REQ-019 On ack in REQ, it SHALL clear P[irq_id_o], drive irq_req_o=0 and irq_id_o=all-ones, and go to IDLE on the next edge; the next ID is presented no earlier than 2 cycles after the ack cycle.
REQ-020 On withdrawal in REQ, it SHALL drive irq_req_o=0 and irq_id_o=all-ones and go to IDLE without clearing P, except that clear_all_i clears all of P.
REQ-021 It SHALL ignore irq_ack_i in IDLE.
REQ-022 With RR_MODE=0, the winner SHALL be the lowest eligible index.
REQ-023 With RR_MODE=1, the winner SHALL be the first eligible index at or above pointer ptr, wrapping from NUM_IRQ-1 to 0.
REQ-024 The pointer ptr SHALL update only on ack, to (acked ID + 1) mod NUM_IRQ; withdrawal SHALL not move ptr.
REQ-025 Event latency SHALL be 2 cycles: an event at cycle N with the FSM idle and the line eligible gives irq_req_o=1 at cycle N+2.
REQ-026 pending_o SHALL equal P directly, with no extra register.
REQ-027 The design SHALL contain no combinational path from any input to irq_req_o or irq_id_o.

Reset
REQ-028 On rst_ni=0, at any time including mid-handshake, the block SHALL asynchronously force:
- P=0, FSM=IDLE, ptr=0.
- irq_req_o=0, irq_id_o=all-ones, pending_o=0.
REQ-029 After rst_ni deasserts, the block SHALL ignore events seen while in reset; it samples irq_event_i from the first edge with rst_ni=1.

Verification
REQ-030 Fixed priority (RR_MODE=0), mask all-ones: pulse events 5, 3 and 40 together at cycle 0 -> id 3 at cycle 2; ack at cycle 4 -> id 5 at cycle 6; ack -> id 40.
REQ-031 Round-robin (RR_MODE=1): keep lines 2, 7 and 9 pending; ack each grant, re-pulse each acked line -> ID sequence 2, 7, 9, 2, 7.
REQ-032 Same-cycle event and ack on line 4 while id 4 is presented -> P[4] stays 1, and id 4 is re-presented 2 cycles later.
REQ-033 Mask line 6 while id 6 is presented -> irq_req_o=0 the next cycle and P[6]=1; unmask -> id 6 is presented again.
REQ-034 clear_all_i during REQ with events pending on lines 1 and 63 -> P=0, irq_req_o=0, id=0xFF, and no further requests.
REQ-035 Assert rst_ni=0 mid-REQ (id 12 presented) -> irq_req_o=0 and id=0xFF immediately, before the next clock edge, and pending_o=0.
